fc_receive_credit_buffer: RTL and testbench

FC_RECEIVE_CREDIT_BUFFER -- requirements
Module: fc_receive_credit_buffer

---
 rtl/fc_receive_credit_buffer_pkg.sv | 31 +++
 rtl/fc_receive_credit_buffer_fifo.sv | 36 +++
 rtl/fc_receive_credit_buffer.sv | 112 +++++++++++
 tb/tb_fc_receive_credit_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_receive_credit_buffer_pkg.sv
// fc_receive_credit_buffer_pkg: credit type codes, FSM encoding and round-robin helpers
package fc_receive_credit_buffer_pkg;
  localparam int NUM_CREDIT_TYPES = 6;
  typedef enum logic [2:0] {
    CT_PH  = 3'd0,
    CT_PD  = 3'd1,
    CT_NPH = 3'd2,
    CT_NPD = 3'd3,
    CT_CH  = 3'd4,
    CT_CD  = 3'd5
  } credit_type_e;
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } fc_state_e;
  function automatic logic [2:0] next_type(input logic [2:0] t);
    return (t == CT_CD) ? 3'd0 : t + 3'd1;
  endfunction
  // first pending type at or after start, wrapping over the six types
  function automatic logic [2:0] rr_pick(input logic [NUM_CREDIT_TYPES-1:0] pend, input logic [2:0] start);
    logic [2:0] pick;
    int idx;
    pick = start;
    for (int i = NUM_CREDIT_TYPES - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NUM_CREDIT_TYPES;
      if (pend[idx]) pick = 3'(idx);
    end
    return pick;
  endfunction
endpackage

// File: rtl/fc_receive_credit_buffer_fifo.sv
// fc_rx_fifo: entry storage with wrapping pointers, occupancy and full/empty
module fc_rx_fifo
  import fc_receive_credit_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 160,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fc_receive_credit_buffer.sv
// fc_receive_credit_buffer: receive FIFO with per-type credit counters and UpdateFC advertisement FSM
module fc_receive_credit_buffer
  import fc_receive_credit_buffer_pkg::*;
#(
  parameter int INFO_SIGNALS = 10,
  parameter int BYTES        = 8,
  parameter int DW           = 4 * BYTES,
  parameter int DATA_WIDTH   = 5 * DW,
  parameter int FIFO_DEPTH   = 64,
  parameter int INIT_CREDITS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     rx_valid,
  input  logic [DATA_WIDTH-1:0]                    rx_data,
  input  logic                                     rd_en,
  output logic [DATA_WIDTH-1:0]                    data_out,
  output logic                                     data_out_valid,
  output logic                                     full,
  output logic                                     empty,
  output logic [NUM_CREDIT_TYPES*INFO_SIGNALS-1:0] credits_received,
  output logic [NUM_CREDIT_TYPES*INFO_SIGNALS-1:0] credits_allocated,
  output logic                                     update_fc_valid,
  input  logic                                     update_fc_ready,
  output logic [2:0]                               update_fc_type,
  output logic [INFO_SIGNALS-1:0]                  update_fc_credits,
  output logic                                     init_done,
  output logic                                     overflow_err,
  output logic                                     type_err
);
  localparam int NT = NUM_CREDIT_TYPES;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0] rx_type, head_type, fc_type, rr_ptr;
  logic type_ok, accept, pop, hs;
  logic [NT-1:0][INFO_SIGNALS-1:0] recv, alloc;
  logic [NT-1:0] pending, pending_next;
  fc_state_e state, state_next;
  assign rx_type   = rx_data[2:0];
  assign head_type = head[2:0];
  assign type_ok   = rx_type < 3'(NT);
  assign accept    = rx_valid && type_ok && (!full || rd_en);
  assign pop       = rd_en && !empty;
  assign hs        = update_fc_valid && update_fc_ready;
  assign credits_received  = recv;
  assign credits_allocated = alloc;
  assign update_fc_type    = fc_type;
  fc_rx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (accept),
    .wr_data(rx_data),
    .rd_en  (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow_err   <= 1'b0;
      type_err       <= 1'b0;
      recv           <= '0;
      alloc          <= {NT{INFO_SIGNALS'(INIT_CREDITS)}};
      pending        <= '0;
    end else begin
      data_out_valid <= pop;
      if (pop) data_out <= head;
      overflow_err <= overflow_err | (rx_valid && type_ok && full && !rd_en);
      type_err     <= type_err | (rx_valid && !type_ok);
      if (accept) recv[rx_type] <= recv[rx_type] + INFO_SIGNALS'(1);
      if (pop) alloc[head_type] <= alloc[head_type] + INFO_SIGNALS'(1);
      pending <= pending_next;
    end
  // a pop in the handshake cycle re-arms its type so the new limit is advertised too
  always_comb begin
    pending_next = pending;
    if (state == ST_SEND && hs) pending_next[fc_type] = 1'b0;
    if (pop) pending_next[head_type] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= ST_INIT;
      fc_type         <= '0;
      rr_ptr          <= '0;
      update_fc_valid <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      state           <= state_next;
      update_fc_valid <= state_next != ST_IDLE;
      init_done       <= init_done | (state == ST_INIT && state_next == ST_IDLE);
      if (state == ST_INIT && hs) fc_type <= next_type(fc_type);
      else if (state == ST_IDLE && |pending) fc_type <= rr_pick(pending, rr_ptr);
      if (state == ST_SEND && hs) rr_ptr <= next_type(fc_type);
    end
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = (hs && fc_type == CT_CD) ? ST_IDLE : ST_INIT;
      ST_IDLE: state_next = |pending ? ST_SEND : ST_IDLE;
      ST_SEND: state_next = hs ? ST_IDLE : ST_SEND;
      default: state_next = ST_INIT;
    endcase
  end
  // credits follow the live allocated count while a type is being advertised
  always_comb
    update_fc_credits = !update_fc_valid ? '0 :
                        (state == ST_INIT) ? INFO_SIGNALS'(INIT_CREDITS) : alloc[fc_type];
endmodule

// File: tb/tb_fc_receive_credit_buffer.sv
// tb_fc_receive_credit_buffer: directed vectors and handshake sequences for fc_receive_credit_buffer
module tb_fc_receive_credit_buffer;
  localparam int IS  = 10;
  localparam int DWD = 160;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic rd_en = 1'b0;
  logic update_fc_ready = 1'b0;
  logic [DWD-1:0] rx_data = '0;
  logic [DWD-1:0] data_out;
  logic data_out_valid, full, empty, update_fc_valid, init_done, overflow_err, type_err;
  logic [6*IS-1:0] credits_received, credits_allocated;
  logic [2:0] update_fc_type;
  logic [IS-1:0] update_fc_credits;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fc_receive_credit_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rd_en            (rd_en),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .full             (full),
    .empty            (empty),
    .credits_received (credits_received),
    .credits_allocated(credits_allocated),
    .update_fc_valid  (update_fc_valid),
    .update_fc_ready  (update_fc_ready),
    .update_fc_type   (update_fc_type),
    .update_fc_credits(update_fc_credits),
    .init_done        (init_done),
    .overflow_err     (overflow_err),
    .type_err         (type_err)
  );
  typedef struct {
    logic [2:0]  t;
    logic [9:0]  c;
  } hs_t;
  hs_t hq[$];
  always @(negedge clk)
    if (rst_n && update_fc_valid && update_fc_ready) hq.push_back('{update_fc_type, update_fc_credits});
  typedef struct {
    logic        v;
    logic [2:0]  t;
    logic [7:0]  tag;
    logic        rd;
    logic        e_empty;
    logic        e_dov;
    logic [15:0] e_out;
    logic        e_terr;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] t, input logic [7:0] tag, input logic rd);
    rx_valid = v;
    rx_data  = DWD'({tag, 5'b0, t});
    rd_en    = rd;
  endtask
  function automatic int recv_sum();
    int s = 0;
    for (int t = 0; t < 6; t++) s += int'(credits_received[t*IS +: IS]);
    return s;
  endfunction
  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("hs_count", 64'(hq.size()), 64'(n));
  endtask
  task automatic chk_hs(input string name, input int i, input logic [2:0] t, input logic [9:0] c);
    if (i < hq.size()) begin
      chk({name, "_type"}, 64'(hq[i].t), 64'(t));
      chk({name, "_credits"}, 64'(hq[i].c), 64'(c));
    end else chk({name, "_missing"}, 64'(hq.size()), 64'(i + 1));
  endtask
  task automatic chk_reset_state(input string p);
    chk({p, "_empty"}, 64'(empty), 64'(1'b1));
    chk({p, "_full"}, 64'(full), 64'(1'b0));
    chk({p, "_fc_valid"}, 64'(update_fc_valid), 64'(1'b0));
    chk({p, "_init_done"}, 64'(init_done), 64'(1'b0));
    chk({p, "_dov"}, 64'(data_out_valid), 64'(1'b0));
    chk({p, "_dout"}, data_out[63:0], 64'(0));
    chk({p, "_recv"}, 64'(credits_received), 64'(0));
    chk({p, "_alloc"}, 64'(credits_allocated), 64'({6{10'd8}}));
    chk({p, "_ovf"}, 64'(overflow_err), 64'(1'b0));
    chk({p, "_terr"}, 64'(type_err), 64'(1'b0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    tbl[0] = '{1'b1, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 3'd0, 8'h12, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 3'd0, 8'h13, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1100, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1200, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h1300, 1'b0};
    tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[7] = '{1'b1, 3'd7, 8'h14, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[8] = '{1'b1, 3'd6, 8'h15, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    update_fc_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    repeat (2) step();
    chk_reset_state("rst");
    rst_n = 1'b1;
    wait_hs(6, 30);
    for (int i = 0; i < 6; i++) chk_hs($sformatf("init%0d", i), i, 3'(i), 10'd8);
    chk("init_done", 64'(init_done), 64'(1'b1));
    chk("idle_fc_valid", 64'(update_fc_valid), 64'(1'b0));
    update_fc_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].t, tbl[i].tag, tbl[i].rd);
      step();
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tbl[i].e_empty));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(1'b0));
      chk($sformatf("v%0d_dov", i), 64'(data_out_valid), 64'(tbl[i].e_dov));
      if (tbl[i].e_dov) chk($sformatf("v%0d_dout", i), 64'(data_out[15:0]), 64'(tbl[i].e_out));
      chk($sformatf("v%0d_terr", i), 64'(type_err), 64'(tbl[i].e_terr));
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("ph_recv", 64'(credits_received), 64'(3));
    chk("ph_alloc", 64'(credits_allocated), 64'({10'd8, 10'd8, 10'd8, 10'd8, 10'd8, 10'd11}));
    chk("ph_ovf", 64'(overflow_err), 64'(1'b0));
    chk("ph_send_valid", 64'(update_fc_valid), 64'(1'b1));
    chk("ph_send_type", 64'(update_fc_type), 64'(3'd0));
    chk("ph_send_credits", 64'(update_fc_credits), 64'(10'd11));
    update_fc_ready = 1'b1;
    wait_hs(7, 10);
    chk_hs("ph_upd", 6, 3'd0, 10'd11);
    repeat (3) step();
    chk("ph_single_upd", 64'(hq.size()), 64'(7));
    update_fc_ready = 1'b0;
    drive(1'b1, 3'd5, 8'h21, 1'b0); step();
    drive(1'b1, 3'd4, 8'h22, 1'b0); step();
    drive(1'b1, 3'd1, 8'h23, 1'b0); step();
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    repeat (3) step();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("rr_hold_valid", 64'(update_fc_valid), 64'(1'b1));
    chk("rr_hold_type", 64'(update_fc_type), 64'(3'd5));
    update_fc_ready = 1'b1;
    wait_hs(10, 20);
    chk_hs("rr_first", 7, 3'd5, 10'd9);
    chk_hs("rr_second", 8, 3'd1, 10'd9);
    chk_hs("rr_third", 9, 3'd4, 10'd9);
    chk("rr_alloc", 64'(credits_allocated), 64'({10'd9, 10'd9, 10'd8, 10'd8, 10'd9, 10'd11}));
    update_fc_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd2, 8'(8'h31 + k), 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b1); step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 3'd0, 8'h00, 1'(k % 2));
      step();
      chk($sformatf("stall%0d_valid", k), 64'(update_fc_valid), 64'(1'b1));
      chk($sformatf("stall%0d_type", k), 64'(update_fc_type), 64'(3'd2));
      chk($sformatf("stall%0d_credits", k), 64'(update_fc_credits), 64'(9 + (k + 1) / 2));
    end
    update_fc_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b1); step();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("stall_last_dout", 64'(data_out[15:0]), 64'(16'h3402));
    chk("stall_after_hs_valid", 64'(update_fc_valid), 64'(1'b0));
    wait_hs(12, 10);
    chk_hs("stall_upd", 10, 3'd2, 10'd11);
    chk_hs("stall_repend", 11, 3'd2, 10'd12);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 3'(i % 6), 8'(i), 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("fill_full", 64'(full), 64'(1'b1));
    chk("fill_empty", 64'(empty), 64'(1'b0));
    chk("fill_ovf", 64'(overflow_err), 64'(1'b0));
    drive(1'b1, 3'd0, 8'hEE, 1'b0); step();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("ovf_full", 64'(full), 64'(1'b1));
    chk("ovf_flag", 64'(overflow_err), 64'(1'b1));
    chk("ovf_recv_sum", 64'(recv_sum()), 64'(74));
    chk("ovf_recv0", 64'(credits_received[IS-1:0]), 64'(14));
    drive(1'b1, 3'd3, 8'hC8, 1'b1); step();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("fullrw_full", 64'(full), 64'(1'b1));
    chk("fullrw_dov", 64'(data_out_valid), 64'(1'b1));
    chk("fullrw_dout", 64'(data_out[15:0]), 64'(16'h0000));
    chk("fullrw_recv_sum", 64'(recv_sum()), 64'(75));
    chk("fullrw_ovf_sticky", 64'(overflow_err), 64'(1'b1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_state("arst");
    #2 rst_n = 1'b1;
    update_fc_ready = 1'b0;
    repeat (3) step();
    chk("init_stall_valid", 64'(update_fc_valid), 64'(1'b1));
    chk("init_stall_type", 64'(update_fc_type), 64'(3'd0));
    chk("init_stall_credits", 64'(update_fc_credits), 64'(10'd8));
    update_fc_ready = 1'b1;
    repeat (2) step();
    update_fc_ready = 1'b0;
    chk("init_mid_type", 64'(update_fc_type), 64'(3'd2));
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("rst2_type", 64'(update_fc_type), 64'(3'd0));
    chk("rst2_valid", 64'(update_fc_valid), 64'(1'b0));
    update_fc_ready = 1'b1;
    base = hq.size();
    wait_hs(base + 6, 30);
    for (int i = 0; i < 6; i++) chk_hs($sformatf("reinit%0d", i), base + i, 3'(i), 10'd8);
    chk("reinit_done", 64'(init_done), 64'(1'b1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
